// File: rtl/cache_ctrl.sv
// Tag/LRU sequencer for a 4-way fully associative cache: same-cycle lookup,
// miss line-fill handshake with true-LRU victim choice, flush, and perf counters.
module cache_ctrl #(
  parameter int ADDR_W = 20,
  parameter int OFFS_W = 4,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  input  logic              mem_data_ready_i,
  output logic              hit_o,
  output logic              miss_o,
  output logic [1:0]        hit_way_o,
  output logic [1:0]        lru_way_o,
  output logic              fill_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = ADDR_W - OFFS_W;

  typedef enum logic {S_IDLE, S_MISS_WAIT} state_t;

  state_t            r_state, w_next_state;
  logic [WAYS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag [WAYS];
  logic [1:0]        r_age [WAYS];
  logic [TAG_W-1:0]  r_held_tag;
  logic [1:0]        r_victim;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic              w_match_any;
  logic [1:0]        w_match_way;
  logic              w_found_invalid;
  logic [1:0]        w_victim;
  logic              w_hit, w_miss, w_fill, w_flush;
  logic              w_touch_en;
  logic [1:0]        w_touch_way;

  assign w_tag = addr_i[ADDR_W-1:OFFS_W];

  always_comb begin
    w_match_any     = 1'b0;
    w_match_way     = '0;
    w_found_invalid = 1'b0;
    w_victim        = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[w] && r_tag[w] == w_tag) begin
        w_match_any = 1'b1;
        w_match_way = 2'(w);
      end
      if (r_age[w] == 2'd3)
        w_victim = 2'(w);
    end
    // Any invalid way beats the LRU way; lowest index wins.
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!r_valid[w] && !w_found_invalid) begin
        w_found_invalid = 1'b1;
        w_victim        = 2'(w);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    w_flush      = 1'b0;
    stall_o      = 1'b0;
    mem_req_o    = 1'b0;
    w_touch_en   = 1'b0;
    w_touch_way  = '0;
    case (r_state)
      S_IDLE: begin
        w_flush     = flush_i;
        w_hit       = req_i & ~flush_i & w_match_any;
        w_miss      = req_i & ~flush_i & ~w_match_any;
        w_touch_en  = w_hit;
        w_touch_way = w_match_way;
        if (w_miss)
          w_next_state = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        w_fill      = mem_data_ready_i;
        w_touch_en  = mem_data_ready_i;
        w_touch_way = r_victim;
        if (mem_data_ready_i)
          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_held_tag <= '0;
      r_victim   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        r_tag[w] <= '0;
        r_age[w] <= 2'(w);
      end
    end else begin
      r_state <= w_next_state;
      if (w_flush)
        r_valid <= '0;
      if (w_miss) begin
        r_held_tag <= w_tag;
        r_victim   <= w_victim;
      end
      if (w_fill) begin
        r_tag[r_victim]   <= r_held_tag;
        r_valid[r_victim] <= 1'b1;
      end
      // Promote to MRU; only ways younger than it age, keeping a permutation.
      if (w_touch_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (2'(w) == w_touch_way)
            r_age[w] <= 2'd0;
          else if (r_age[w] < r_age[w_touch_way])
            r_age[w] <= r_age[w] + 2'd1;
        end
      end
      if (w_hit && r_hit_cnt != '1)
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_o      = w_hit;
  assign miss_o     = w_miss;
  assign hit_way_o  = w_hit ? w_match_way : 2'd0;
  assign lru_way_o  = r_victim;
  assign fill_o     = w_fill;
  assign mem_addr_o = {r_held_tag, {OFFS_W{1'b0}}};
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized traffic
// checked against a recency-list model of the cache.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, req_i = 1'b0, flush_i = 1'b0, rdy_i = 1'b0;
  logic [19:0] addr_i = '0;
  logic        hit_o, miss_o, fill_o, stall_o, mem_req_o;
  logic [1:0]  hit_way_o, lru_way_o;
  logic [19:0] mem_addr_o;
  logic [15:0] hit_cnt_o, miss_cnt_o;
  logic [8:0]  obs, exp9;

  int checks = 0;
  int errors = 0;

  cache_ctrl #(.ADDR_W(20), .OFFS_W(4), .WAYS(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .flush_i(flush_i),
    .mem_data_ready_i(rdy_i), .hit_o(hit_o), .miss_o(miss_o), .hit_way_o(hit_way_o),
    .lru_way_o(lru_way_o), .fill_o(fill_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  assign obs = {hit_o, miss_o, hit_way_o, lru_way_o, fill_o, stall_o, mem_req_o};

  initial begin
    #2000000;
    $display("FAIL watchdog expired simulation time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] ob(input bit h, input bit m, input logic [1:0] hw,
                                    input logic [1:0] lw, input bit f, input bit s, input bit mr);
    return {h, m, hw, lw, f, s, mr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input logic [19:0] a, input bit f, input bit rd);
    req_i = r; addr_i = a; flush_i = f; rdy_i = rd;
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, '0, 0, 0);
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic fill_tag(input logic [15:0] t);
    drive(1, {t, 4'h0}, 0, 0);
    cyc();
    drive(1, {t, 4'h0}, 0, 1);
    cyc();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, '0, 0, 0);
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 9'd0); end
    checks++; if ({mem_addr_o, hit_cnt_o, miss_cnt_o} !== 52'd0) begin errors++;
      $display("FAIL reset_regs got addr=%h hc=%h mc=%h exp 0", mem_addr_o, hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_miss_fill();
    do_reset();
    drive(1, 20'h01230, 0, 0);
    exp9 = ob(0, 1, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp9) begin errors++; $display("FAIL mf_miss got=%b exp=%b", obs, exp9); end
    cyc();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 20'h01230, 0, i == 3);
      exp9 = ob(0, 0, 0, 0, i == 3, 1, 1);
      checks++; if (obs !== exp9) begin errors++; $display("FAIL mf_wait%0d got=%b exp=%b", i, obs, exp9); end
      checks++; if (mem_addr_o !== 20'h01230) begin errors++; $display("FAIL mf_addr got=%h exp=01230", mem_addr_o); end
      cyc();
    end
    drive(1, 20'h01230, 0, 0);
    exp9 = ob(1, 0, 0, 0, 0, 0, 0);
    checks++; if (obs !== exp9) begin errors++; $display("FAIL mf_replay_hit got=%b exp=%b", obs, exp9); end
    cyc();
    drive(0, '0, 0, 0);
    checks++; if ({hit_cnt_o, miss_cnt_o} !== {16'd1, 16'd1}) begin errors++;
      $display("FAIL mf_counts got hc=%0d mc=%0d exp 1 1", hit_cnt_o, miss_cnt_o); end
  endtask

  task automatic test_lru_victim();
    do_reset();
    for (int t = 1; t <= 4; t++) fill_tag(16'(t));
    drive(1, 20'h00010, 0, 0);
    exp9 = ob(1, 0, 0, 3, 0, 0, 0);
    checks++; if (obs !== exp9) begin errors++; $display("FAIL lru_hit1 got=%b exp=%b", obs, exp9); end
    cyc();
    drive(1, 20'h00050, 0, 0);
    checks++; if (miss_o !== 1'b1) begin errors++; $display("FAIL lru_miss5 got=%b exp=1", miss_o); end
    cyc();
    drive(1, 20'h00050, 0, 1);
    checks++; if (lru_way_o !== 2'd1) begin errors++; $display("FAIL lru_victim5 got=%0d exp=1", lru_way_o); end
    checks++; if (mem_addr_o !== 20'h00050) begin errors++; $display("FAIL lru_addr5 got=%h exp=00050", mem_addr_o); end
    cyc();
    drive(1, 20'h00020, 0, 0);
    checks++; if (miss_o !== 1'b1) begin errors++; $display("FAIL lru_miss2 got=%b exp=1", miss_o); end
    cyc();
    drive(1, 20'h00020, 0, 1);
    checks++; if (lru_way_o !== 2'd2) begin errors++; $display("FAIL lru_victim2 got=%0d exp=2", lru_way_o); end
    cyc();
    drive(1, 20'h00010, 0, 0);
    checks++; if ({hit_o, hit_way_o} !== 3'b100) begin errors++; $display("FAIL lru_hit1b got=%b exp=100", {hit_o, hit_way_o}); end
    cyc();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_miss_wait_ignore();
    do_reset();
    drive(1, 20'h01230, 0, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      drive(1, 20'hFFFF0, i == 0, 0);
      exp9 = ob(0, 0, 0, 0, 0, 1, 1);
      checks++; if (obs !== exp9) begin errors++; $display("FAIL mw_ignore%0d got=%b exp=%b", i, obs, exp9); end
      checks++; if (mem_addr_o !== 20'h01230) begin errors++; $display("FAIL mw_addr%0d got=%h exp=01230", i, mem_addr_o); end
      cyc();
    end
    drive(1, 20'hFFFF0, 0, 1);
    cyc();
    drive(1, 20'h01230, 0, 0);
    checks++; if ({hit_o, hit_way_o} !== 3'b100) begin errors++; $display("FAIL mw_no_flush got=%b exp=100", {hit_o, hit_way_o}); end
    cyc();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    drive(1, 20'h04560, 0, 0);
    cyc();
    rst_i = 1'b1;
    drive(1, 20'h04560, 0, 1);
    cyc();
    rst_i = 1'b0;
    drive(0, '0, 0, 0);
    checks++; if (obs !== 9'd0) begin errors++; $display("FAIL rm_outputs got=%b exp=%b", obs, 9'd0); end
    checks++; if ({hit_cnt_o, miss_cnt_o} !== 32'd0) begin errors++; $display("FAIL rm_counts got hc=%0d mc=%0d exp 0 0", hit_cnt_o, miss_cnt_o); end
    drive(1, 20'h04560, 0, 0);
    checks++; if ({hit_o, miss_o} !== 2'b01) begin errors++; $display("FAIL rm_remiss got=%b exp=01", {hit_o, miss_o}); end
    cyc();
    drive(1, 20'h04560, 0, 1);
    cyc();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_flush_priority();
    do_reset();
    fill_tag(16'h000A); fill_tag(16'h000B); fill_tag(16'h000C);
    drive(1, 20'h000C0, 0, 0);
    checks++; if ({hit_o, hit_way_o} !== 3'b110) begin errors++; $display("FAIL fl_hit_way2 got=%b exp=110", {hit_o, hit_way_o}); end
    cyc();
    drive(1, 20'h000C0, 1, 0);
    exp9 = ob(0, 0, 0, 2, 0, 0, 0);
    checks++; if (obs !== exp9) begin errors++; $display("FAIL fl_priority got=%b exp=%b", obs, exp9); end
    cyc();
    drive(1, 20'h000C0, 0, 0);
    checks++; if ({hit_cnt_o, miss_cnt_o} !== {16'd1, 16'd3}) begin errors++;
      $display("FAIL fl_counts got hc=%0d mc=%0d exp 1 3", hit_cnt_o, miss_cnt_o); end
    checks++; if ({hit_o, miss_o} !== 2'b01) begin errors++; $display("FAIL fl_remiss got=%b exp=01", {hit_o, miss_o}); end
    cyc();
    drive(1, 20'h000C0, 0, 1);
    checks++; if (lru_way_o !== 2'd0) begin errors++; $display("FAIL fl_victim got=%0d exp=0", lru_way_o); end
    cyc();
    drive(0, '0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    fill_tag(16'h0007);
    drive(1, 20'h00070, 0, 0);
    repeat (65534) cyc();
    checks++; if (hit_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=FFFE", hit_cnt_o); end
    repeat (3) cyc();
    checks++; if (hit_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=FFFF", hit_cnt_o); end
    checks++; if (miss_cnt_o !== 16'd1) begin errors++; $display("FAIL sat_miss got=%0d exp=1", miss_cnt_o); end
    drive(0, '0, 0, 0);
  endtask

  // Reference model: ways kept in a recency list, most recent first.
  bit          m_busy;
  bit          m_valid [4];
  logic [15:0] m_tag [4];
  int          m_order [$];
  logic [15:0] m_held;
  logic [1:0]  m_vict;
  int          m_hc, m_mc;

  task automatic model_touch(input int w);
    foreach (m_order[i]) if (m_order[i] == w) begin m_order.delete(i); break; end
    m_order.push_front(w);
  endtask

  task automatic test_random();
    int hitw, inv;
    bit r, f, rd, e_hit, e_miss;
    logic [15:0] t;
    do_reset();
    m_busy = 0; m_hc = 0; m_mc = 0; m_held = '0; m_vict = '0;
    m_order = {0, 1, 2, 3};
    for (int w = 0; w < 4; w++) begin m_valid[w] = 0; m_tag[w] = '0; end
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(3) != 0);
      f  = ($urandom_range(15) == 0);
      rd = ($urandom_range(2) == 0);
      t  = 16'($urandom_range(6));
      drive(r, {t, 4'($urandom_range(15))}, f, rd);
      hitw = -1;
      if (!m_busy && r && !f)
        for (int w = 0; w < 4; w++) if (m_valid[w] && m_tag[w] == t) hitw = w;
      e_hit  = hitw >= 0;
      e_miss = !m_busy && r && !f && hitw < 0;
      exp9 = ob(e_hit, e_miss, e_hit ? 2'(hitw) : 2'd0, m_vict, m_busy && rd, m_busy, m_busy);
      checks++; if (obs !== exp9) begin errors++; $display("FAIL rnd_obs n=%0d got=%b exp=%b", n, obs, exp9); end
      checks++; if ({hit_cnt_o, miss_cnt_o} !== {16'(m_hc), 16'(m_mc)}) begin errors++;
        $display("FAIL rnd_cnt n=%0d got hc=%0d mc=%0d exp %0d %0d", n, hit_cnt_o, miss_cnt_o, m_hc, m_mc); end
      if (m_busy) begin
        checks++; if (mem_addr_o !== {m_held, 4'h0}) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr_o, {m_held, 4'h0}); end
      end
      if (!m_busy) begin
        if (f) for (int w = 0; w < 4; w++) m_valid[w] = 0;
        else if (e_hit) begin model_touch(hitw); if (m_hc < 65535) m_hc++; end
        else if (e_miss) begin
          inv = -1;
          for (int w = 3; w >= 0; w--) if (!m_valid[w]) inv = w;
          m_vict = (inv >= 0) ? 2'(inv) : 2'(m_order[$]);
          m_held = t; m_busy = 1;
          if (m_mc < 65535) m_mc++;
        end
      end else if (rd) begin
        m_tag[m_vict] = m_held; m_valid[m_vict] = 1; model_touch(int'(m_vict)); m_busy = 0;
      end
      cyc();
    end
    drive(0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_lru_victim();
    test_miss_wait_ignore();
    test_reset_mid_miss();
    test_flush_priority();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
